// File: rtl/emergency_pkg.sv
// Shared definitions for the emergency-system blocks: state encoding and timer width.
package emergency_pkg;

  localparam int STATE_W = 3;
  localparam int TIMER_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_OVERLOAD  = 3'd1,
    ST_SOS_BRAKE = 3'd2,
    ST_SOS_DOOR  = 3'd3,
    ST_SOS_HOLD  = 3'd4,
    ST_LOCKOUT   = 3'd5
  } state_t;

  function automatic logic in_door_phase(input state_t s);
    return (s == ST_SOS_DOOR) || (s == ST_SOS_HOLD);
  endfunction

endpackage

// File: rtl/emergency_timer.sv
// Loadable down-counter that stops at zero and flags it.
module emergency_timer
  import emergency_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/emergency_sequencer.sv
// Emergency sequencer: overload buzzer/inhibit handling and the SOS brake-door-hold-lockout sequence.
module emergency_sequencer
  import emergency_pkg::*;
#(
  parameter int unsigned BUZZ_HALF = 25_000_000,
  parameter int unsigned DOOR_HOLD = 500_000_000,
  parameter int          CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sos_mode,
  input  logic               weight_limit_exceeded,
  input  logic               motor_moving,
  input  logic               at_floor,
  input  logic               clear_req,
  output logic               motor_stop,
  output logic               motor_inhibit,
  output logic               door_open_cmd,
  output logic               alarm,
  output logic               buzzer,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   sos_count
);

  state_t state, next_state;
  logic buzz_load, buzz_en, buzz_zero;
  logic hold_load, hold_en, hold_zero;
  logic [TIMER_W-1:0] buzz_val, hold_val;
  logic [3:0] cmd_next;
  logic entering_ovl, staying_ovl, entering_brake;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (sos_mode) next_state = ST_SOS_BRAKE;
                    else if (weight_limit_exceeded && !motor_moving) next_state = ST_OVERLOAD;
      ST_OVERLOAD:  if (sos_mode) next_state = ST_SOS_BRAKE;
                    else if (!weight_limit_exceeded) next_state = ST_IDLE;
      ST_SOS_BRAKE: if (at_floor && !motor_moving) next_state = ST_SOS_DOOR;
      ST_SOS_DOOR:  next_state = ST_SOS_HOLD;
      ST_SOS_HOLD:  if (hold_zero) next_state = ST_LOCKOUT;
      ST_LOCKOUT:   if (clear_req && !sos_mode) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  assign entering_ovl   = (next_state == ST_OVERLOAD) && (state != ST_OVERLOAD);
  assign staying_ovl    = (next_state == ST_OVERLOAD) && (state == ST_OVERLOAD);
  assign entering_brake = (next_state == ST_SOS_BRAKE) && (state != ST_SOS_BRAKE);

  // Buzzer timer counts BUZZ_HALF-1..0 per half-period; it is cleared whenever we are not in overload.
  always_comb begin
    buzz_load = 1'b0;
    buzz_en   = 1'b0;
    buzz_val  = '0;
    if (entering_ovl || (staying_ovl && buzz_zero)) begin
      buzz_load = 1'b1;
      buzz_val  = TIMER_W'(BUZZ_HALF - 1);
    end else if (staying_ovl) begin
      buzz_en = 1'b1;
    end else begin
      buzz_load = 1'b1;
    end
  end

  // Hold timer also ticks during the single DOOR cycle so HOLD lasts exactly DOOR_HOLD cycles.
  always_comb begin
    hold_load = 1'b0;
    hold_en   = 1'b0;
    hold_val  = '0;
    if (next_state == ST_SOS_DOOR && state != ST_SOS_DOOR) begin
      hold_load = 1'b1;
      hold_val  = TIMER_W'(DOOR_HOLD);
    end else if (in_door_phase(state)) begin
      hold_en = 1'b1;
    end else begin
      hold_load = 1'b1;
    end
  end

  emergency_timer #(.W(TIMER_W)) u_buzz_timer (
    .clk(clk), .rst_n(rst_n), .load(buzz_load), .en(buzz_en),
    .load_val(buzz_val), .zero(buzz_zero)
  );

  emergency_timer #(.W(TIMER_W)) u_hold_timer (
    .clk(clk), .rst_n(rst_n), .load(hold_load), .en(hold_en),
    .load_val(hold_val), .zero(hold_zero)
  );

  // Command bits {stop, inhibit, door, alarm} decoded from the state being entered, then registered.
  always_comb begin
    cmd_next = 4'b0000;
    case (next_state)
      ST_OVERLOAD:  cmd_next = 4'b0110;
      ST_SOS_BRAKE: cmd_next = 4'b1101;
      ST_SOS_DOOR:  cmd_next = 4'b1011;
      ST_SOS_HOLD:  cmd_next = 4'b1011;
      ST_LOCKOUT:   cmd_next = 4'b1101;
      default:      cmd_next = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {motor_stop, motor_inhibit, door_open_cmd, alarm} <= 4'b0000;
      buzzer    <= 1'b0;
      sos_count <= '0;
    end else begin
      {motor_stop, motor_inhibit, door_open_cmd, alarm} <= cmd_next;
      if (next_state != ST_OVERLOAD)
        buzzer <= 1'b0;
      else if (entering_ovl)
        buzzer <= 1'b1;
      else if (buzz_zero)
        buzzer <= ~buzzer;
      if (entering_brake && sos_count != {CNT_W{1'b1}})
        sos_count <= sos_count + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_emergency_sequencer.sv
// Scoreboard bench: stimulus queues expected per-cycle responses, a negedge monitor pops and compares.
module tb_emergency_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   logic sos_mode, weight_limit_exceeded, motor_moving, at_floor, clear_req;
   logic motor_stop, motor_inhibit, door_open_cmd, alarm, buzzer;
   logic [2:0] state_o;
   logic [1:0] sos_count;

   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   int expCnt = 0;

   typedef struct {
      string      name;
      int         cyc;
      logic [2:0] st;
      logic [3:0] cmd;
      logic       buzz;
      logic [1:0] cnt;
   } exp_t;

   exp_t sb[$];

   emergency_sequencer #(.BUZZ_HALF(4), .DOOR_HOLD(10), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .sos_mode(sos_mode),
      .weight_limit_exceeded(weight_limit_exceeded), .motor_moving(motor_moving),
      .at_floor(at_floor), .clear_req(clear_req), .motor_stop(motor_stop),
      .motor_inhibit(motor_inhibit), .door_open_cmd(door_open_cmd), .alarm(alarm),
      .buzzer(buzzer), .state_o(state_o), .sos_count(sos_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expectations
   always @(posedge clk) cyc <= cyc + 1;

   // Expected {stop, inhibit, door, alarm} for each state code
   function automatic logic [3:0] cmdOf(input int st);
      case (st)
         1:       return 4'b0110;
         2:       return 4'b1101;
         3:       return 4'b1011;
         4:       return 4'b1011;
         5:       return 4'b1101;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic applyStimulus(input logic s, input logic w, input logic m,
                                input logic f, input logic c);
      sos_mode              = s;
      weight_limit_exceeded = w;
      motor_moving          = m;
      at_floor              = f;
      clear_req             = c;
   endtask

   task automatic checkOutput(input string name, input int st, input logic bz);
      exp_t e;
      e.name = name;
      e.cyc  = cyc + 1;
      e.st   = 3'(st);
      e.cmd  = cmdOf(st);
      e.buzz = bz;
      e.cnt  = 2'(expCnt);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic doorSequence(input string name);
      checkOutput({name, "_door"}, 3, 1'b0);
      for (int i = 0; i < 10; i++) checkOutput({name, "_hold"}, 4, 1'b0);
      checkOutput({name, "_lockout"}, 5, 1'b0);
   endtask

   task automatic bumpCount();
      if (expCnt < 3) expCnt = expCnt + 1;
   endtask

   // Monitor pops due expectations on the falling edge and compares against DUT outputs
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         logic [9:0] got, want;
         e = sb.pop_front();
         got  = {state_o, motor_stop, motor_inhibit, door_open_cmd, alarm, buzzer, sos_count};
         want = {e.st, e.cmd, e.buzz, e.cnt};
         compared = compared + 1;
         if (e.cyc != cyc || got !== want) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s cyc=%0d got st=%0d cmd=%b buzz=%b cnt=%0d want st=%0d cmd=%b buzz=%b cnt=%0d",
                     e.name, cyc, state_o,
                     {motor_stop, motor_inhibit, door_open_cmd, alarm}, buzzer, sos_count,
                     e.st, e.cmd, e.buzz, e.cnt);
         end
      end
   end

   // Watchdog guards against a hung simulation
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout got running want finished");
      mismatched = mismatched + 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Main stimulus sequence
   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("reset", 0, 1'b0);
      checkOutput("reset_hold", 0, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle", 0, 1'b0);
      compared = compared + 1;
      if (state_o !== 3'd0 || sos_count !== 2'd0) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL direct_idle got st=%0d cnt=%0d want st=0 cnt=0", state_o, sos_count);
      end

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) checkOutput("ovl_while_moving", 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         checkOutput("ovl_buzz", 1, ((k / 4) % 2) == 0);
         compared = compared + 1;
         if (buzzer !== (((k / 4) % 2) == 0) || state_o !== 3'd1 || motor_inhibit !== 1'b1) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL direct_ovl_buzz k=%0d got st=%0d buzz=%b inh=%b want st=1 buzz=%b inh=1",
                     k, state_o, buzzer, motor_inhibit, ((k / 4) % 2) == 0);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ovl_exit", 0, 1'b0);
      compared = compared + 1;
      if (state_o !== 3'd0 || buzzer !== 1'b0) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL direct_ovl_exit got st=%0d buzz=%b want st=0 buzz=0", state_o, buzzer);
      end

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      bumpCount();
      checkOutput("sos_over_weight", 2, 1'b0);
      compared = compared + 1;
      if (state_o !== 3'd2 || motor_stop !== 1'b1 || sos_count !== 2'd1 || buzzer !== 1'b0) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL direct_sos_over_weight got st=%0d stop=%b cnt=%0d buzz=%b want st=2 stop=1 cnt=1 buzz=0",
                  state_o, motor_stop, sos_count, buzzer);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) checkOutput("brake_no_abort", 2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      doorSequence("sos1");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("lockout_ignores_weight", 5, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("lockout_clear", 0, 1'b0);
      compared = compared + 1;
      if (state_o !== 3'd0 || door_open_cmd !== 1'b0) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL direct_lockout_clear got st=%0d door=%b want st=0 door=0", state_o, door_open_cmd);
      end

      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      bumpCount();
      checkOutput("sos_moving", 2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) checkOutput("brake_wait_floor", 2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      doorSequence("sos2");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("clear_with_sos", 5, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lockout_stay", 5, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("clear_ok", 0, 1'b0);

      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         bumpCount();
         checkOutput("sat_brake", 2, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         doorSequence("sat");
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         checkOutput("sat_clear", 0, 1'b0);
      end

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bumpCount();
      checkOutput("rst_brake", 2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("rst_door", 3, 1'b0);
      for (int i = 0; i < 3; i++) checkOutput("rst_hold", 4, 1'b0);
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      expCnt = 0;
      checkOutput("mid_hold_reset", 0, 1'b0);
      compared = compared + 1;
      if (state_o !== 3'd0 || sos_count !== 2'd0 ||
          {motor_stop, motor_inhibit, door_open_cmd, alarm, buzzer} !== 5'b00000) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL direct_mid_hold_reset got st=%0d cnt=%0d outs=%b want st=0 cnt=0 outs=00000",
                  state_o, sos_count, {motor_stop, motor_inhibit, door_open_cmd, alarm, buzzer});
      end
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("after_reset", 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bumpCount();
      checkOutput("count_restart", 2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         compared = compared + 1;
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s got unchecked want checked", e.name);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/emergency_sequencer.md
EMERGENCY_SEQUENCER -- requirements
Module: emergency_sequencer

Interface
REQ-001 SHALL have parameter BUZZ_HALF, default 25_000_000, buzzer half-period in clk cycles (≥1).
REQ-002 SHALL have parameter DOOR_HOLD, default 500_000_000, SOS door-open hold time in clk cycles (≥1).
REQ-003 SHALL have parameter CNT_W, default 8, width of the SOS event counter.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- sos_mode, in, 1: SOS request level from the SOS handler.
- weight_limit_exceeded, in, 1: overload level from weight control.
- motor_moving, in, 1: cab in motion.
- at_floor, in, 1: cab aligned with a landing.
- clear_req, in, 1: maintenance-key release pulse.
- motor_stop, out, 1: emergency brake command.
- motor_inhibit, out, 1: departure block.
- door_open_cmd, out, 1: force door open.
- alarm, out, 1: SOS alarm lamp.
- buzzer, out, 1: overload buzzer.
- state_o, out, 3: current state code.
- sos_count, out, CNT_W: SOS entries since reset.

Function
REQ-005 SHALL be a Moore FSM; all outputs registered; inputs sampled on the rising clk edge; response visible the cycle after the sampling edge.
REQ-006 States and codes: IDLE=0, OVERLOAD=1, SOS_BRAKE=2, SOS_DOOR=3, SOS_HOLD=4, LOCKOUT=5; codes 6–7 unreachable, recover to IDLE.
REQ-007 From any non-SOS state (IDLE, OVERLOAD), sos_mode=1 SHALL move to SOS_BRAKE; SOS has priority over overload on simultaneous assertion.
REQ-008 IDLE -> OVERLOAD when weight_limit_exceeded=1, sos_mode=0, motor_moving=0.
REQ-009 OVERLOAD: motor_inhibit=1, door_open_cmd=1, buzzer starts at 1 on entry and toggles every BUZZ_HALF cycles; weight_limit_exceeded=0 -> IDLE; buzzer=0 and timer cleared on exit.
REQ-010 Overload while motor_moving=1 SHALL be ignored; evaluated again once the cab stops.
REQ-011 SOS_BRAKE: motor_stop=1, motor_inhibit=1, alarm=1; -> SOS_DOOR when at_floor=1 and motor_moving=0.
REQ-012 SOS_DOOR: door_open_cmd=1, motor_stop=1, alarm=1; hold timer loaded with DOOR_HOLD on entry; -> SOS_HOLD next cycle.
REQ-013 SOS_HOLD: outputs as SOS_DOOR; timer decrements each cycle; at 0 -> LOCKOUT. An SOS_HOLD dwell of exactly DOOR_HOLD cycles SHALL be met.
REQ-014 LOCKOUT: motor_stop=1, motor_inhibit=1, alarm=1, door_open_cmd=0; -> IDLE only when clear_req=1 and sos_mode=0 in the same cycle.
REQ-015 After entry to SOS_BRAKE, deassertion of sos_mode SHALL NOT abort the sequence; clear_req SHALL be ignored outside LOCKOUT.
REQ-016 sos_count SHALL increment by 1 on each entry to SOS_BRAKE; saturates at 2^CNT_W−1 (no wrap).
REQ-017 weight_limit_exceeded SHALL be ignored in all SOS states and in LOCKOUT.
REQ-018 In IDLE all command outputs = 0.

Reset
REQ-019 rst_n=0 at a clk edge SHALL force IDLE, all outputs 0, sos_count=0, and timers=0, including mid-sequence; it takes precedence over all inputs.
REQ-020 The first input evaluation SHALL occur at the first edge with rst_n=1.

Structure
REQ-021 State codes and state width SHALL live in shared package emergency_pkg, reused by emergency-system blocks.
REQ-022 One sub-module, emergency_timer, SHALL be used: a loadable down-counter with a zero flag, instantiated once for buzzer toggling and once for the door hold.

Verification (BUZZ_HALF=4, DOOR_HOLD=10, CNT_W=2)
REQ-023 Weight=1, motor stopped, 20 cycles -> state 1, motor_inhibit=1, buzzer toggles every 4 cycles starting at 1; weight=0 -> IDLE next cycle, buzzer=0.
REQ-024 sos_mode and weight raised in the same cycle -> state 2, motor_stop=1, sos_count=1, buzzer stays 0.
REQ-025 SOS while motor_moving=1, at_floor=0; at_floor=1 and motor_moving=0 after 7 cycles -> SOS_DOOR, door_open_cmd=1 for exactly 11 cycles (DOOR + HOLD), then LOCKOUT.
REQ-026 LOCKOUT: clear_req with sos_mode=1 -> stays 5; clear_req with sos_mode=0 -> IDLE, outputs 0.
REQ-027 Five complete SOS cycles -> sos_count reads 3 (saturated).
REQ-028 rst_n=0 for one cycle during SOS_HOLD -> IDLE, all outputs 0, sos_count=0 next cycle.
